// File: rtl/aes_core_pkg.sv
// Shared AES-128 constants, types and byte/column transforms used by the
// iterative core and its key-schedule step.
package aes_package;

  localparam int DATA_WIDTH = 128;
  localparam int NUM_ROUNDS = 10;

  // state[c][r]: column c, row r; state[0][0] sits in bits [127:120]
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {IDLE, ENC, KEXP, DEC} fsm_state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entries 1..10 are the real Rcon values; the zero padding keeps any 4-bit index legal
  localparam logic [0:15][7:0] RCON = 128'h00_01_02_04_08_10_20_40_80_1b_36_00_00_00_00_00;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t m;
    for (int c = 0; c < 4; c++) begin
      m[c][0] = gmul(s[c][0], 4'h2) ^ gmul(s[c][1], 4'h3) ^ s[c][2] ^ s[c][3];
      m[c][1] = s[c][0] ^ gmul(s[c][1], 4'h2) ^ gmul(s[c][2], 4'h3) ^ s[c][3];
      m[c][2] = s[c][0] ^ s[c][1] ^ gmul(s[c][2], 4'h2) ^ gmul(s[c][3], 4'h3);
      m[c][3] = gmul(s[c][0], 4'h3) ^ s[c][1] ^ s[c][2] ^ gmul(s[c][3], 4'h2);
    end
    return m;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t m;
    for (int c = 0; c < 4; c++) begin
      m[c][0] = gmul(s[c][0], 4'he) ^ gmul(s[c][1], 4'hb) ^ gmul(s[c][2], 4'hd) ^ gmul(s[c][3], 4'h9);
      m[c][1] = gmul(s[c][0], 4'h9) ^ gmul(s[c][1], 4'he) ^ gmul(s[c][2], 4'hb) ^ gmul(s[c][3], 4'hd);
      m[c][2] = gmul(s[c][0], 4'hd) ^ gmul(s[c][1], 4'h9) ^ gmul(s[c][2], 4'he) ^ gmul(s[c][3], 4'hb);
      m[c][3] = gmul(s[c][0], 4'hb) ^ gmul(s[c][1], 4'hd) ^ gmul(s[c][2], 4'h9) ^ gmul(s[c][3], 4'he);
    end
    return m;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// One step of the AES-128 key schedule: round key r from round key r-1.
module aes_key_expand
  import aes_package::*;
(
  input  logic [DATA_WIDTH-1:0] prev_key,
  input  logic [3:0]            round,
  output logic [DATA_WIDTH-1:0] next_key
);

  logic [31:0] temp;

  assign temp = sub_word(rot_word(prev_key[31:0])) ^ {RCON[round], 24'h000000};

  assign next_key[127:96] = prev_key[127:96] ^ temp;
  assign next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];

endmodule

// File: rtl/aes_core.sv
// Iterative AES-128 engine: one round per clock, encryption keys generated on
// the fly, decryption keys pre-expanded into a round-key array.
module aes_core
  import aes_package::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_encryption,
  input  logic                  start_decryption,
  input  logic [DATA_WIDTH-1:0] plaintext_encryption,
  input  logic [DATA_WIDTH-1:0] cyphertext_decryption,
  input  logic [DATA_WIDTH-1:0] key_encryption,
  output logic [DATA_WIDTH-1:0] cyphertext_encryption,
  output logic [DATA_WIDTH-1:0] plaintext_decryption,
  output logic                  done_encryption,
  output logic                  done_decyption
);

  fsm_state_t            fsm_reg;
  logic [3:0]            round_reg;
  state_t                state_reg;
  logic [DATA_WIDTH-1:0] key_reg;
  logic [DATA_WIDTH-1:0] block_reg;
  logic [DATA_WIDTH-1:0] rk_reg [0:NUM_ROUNDS];

  logic [DATA_WIDTH-1:0] next_key;
  logic [DATA_WIDTH-1:0] enc_out;
  logic [DATA_WIDTH-1:0] dec_out;
  logic [DATA_WIDTH-1:0] dec_ark;
  logic [3:0]            dec_idx;
  logic                  last_round;
  wire state_t           sb, sr, isr, isb;

  aes_key_expand u_key_expand (
    .prev_key (key_reg),
    .round    (round_reg),
    .next_key (next_key)
  );

  // Byte-wise substitution and row rotation for both directions
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int C = gi / 4;
    localparam int R = gi % 4;
    assign sb[C][R]  = SBOX[state_reg[C][R]];
    assign sr[C][R]  = sb[(C + R) % 4][R];
    assign isr[C][R] = state_reg[(C + 4 - R) % 4][R];
    assign isb[C][R] = INV_SBOX[isr[C][R]];
  end

  assign last_round = (round_reg == 4'(NUM_ROUNDS));
  assign enc_out    = (last_round ? sr : mix_columns(sr)) ^ next_key;
  assign dec_idx    = (round_reg <= 4'(NUM_ROUNDS)) ? 4'(NUM_ROUNDS) - round_reg : 4'd0;
  assign dec_ark    = isb ^ rk_reg[dec_idx];
  assign dec_out    = last_round ? dec_ark : inv_mix_columns(dec_ark);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_reg               <= IDLE;
      round_reg             <= '0;
      state_reg             <= '0;
      key_reg               <= '0;
      block_reg             <= '0;
      cyphertext_encryption <= '0;
      plaintext_decryption  <= '0;
      done_encryption       <= 1'b0;
      done_decyption        <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_reg[i] <= '0;
    end else begin
      done_encryption <= 1'b0;
      done_decyption  <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start_encryption) begin
            key_reg   <= key_encryption;
            state_reg <= plaintext_encryption ^ key_encryption;
            round_reg <= 4'd1;
            fsm_reg   <= ENC;
          end else if (start_decryption) begin
            key_reg   <= key_encryption;
            rk_reg[0] <= key_encryption;
            block_reg <= cyphertext_decryption;
            round_reg <= 4'd1;
            fsm_reg   <= KEXP;
          end
        end
        ENC: begin
          state_reg <= enc_out;
          key_reg   <= next_key;
          round_reg <= round_reg + 4'd1;
          if (last_round) begin
            cyphertext_encryption <= enc_out;
            done_encryption       <= 1'b1;
            fsm_reg               <= IDLE;
          end
        end
        KEXP: begin
          // Ten expansion cycles fill rk[1..10]; the extra cycle applies the initial whitening
          if (round_reg <= 4'(NUM_ROUNDS)) begin
            rk_reg[round_reg] <= next_key;
            key_reg           <= next_key;
            round_reg         <= round_reg + 4'd1;
          end else begin
            state_reg <= block_reg ^ rk_reg[NUM_ROUNDS];
            round_reg <= 4'd1;
            fsm_reg   <= DEC;
          end
        end
        DEC: begin
          state_reg <= dec_out;
          round_reg <= round_reg + 4'd1;
          if (last_round) begin
            plaintext_decryption <= dec_out;
            done_decyption       <= 1'b1;
            fsm_reg              <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core.sv
// Directed bench for aes_core: FIPS-197 vectors, round trips, start-pulse
// protocol and mid-operation reset, checked through an expected-result queue.
module tb_aes_core;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_encryption = 1'b0;
  logic         start_decryption = 1'b0;
  logic [127:0] plaintext_encryption = '0;
  logic [127:0] cyphertext_decryption = '0;
  logic [127:0] key_encryption = '0;
  logic [127:0] cyphertext_encryption;
  logic [127:0] plaintext_decryption;
  logic         done_encryption;
  logic         done_decyption;

  typedef struct {
    bit           is_dec;
    bit           chk;
    logic [127:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   failed = 0;

  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] RT_PT  = 128'h00000101030307070f0f1f1f3f3f7f7f;
  localparam int           TIMEOUT = 40;

  aes_core dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_encryption      (start_encryption),
    .start_decryption      (start_decryption),
    .plaintext_encryption  (plaintext_encryption),
    .cyphertext_decryption (cyphertext_decryption),
    .key_encryption        (key_encryption),
    .cyphertext_encryption (cyphertext_encryption),
    .plaintext_decryption  (plaintext_decryption),
    .done_encryption       (done_encryption),
    .done_decyption        (done_decyption)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_dec, input bit chk, input logic [127:0] exp);
    exp_t e;
    e.is_dec = is_dec;
    e.chk    = chk;
    e.exp    = exp;
    sb_q.push_back(e);
  endtask

  // Present a start pulse so that it is sampled on exactly one rising edge
  task automatic start_op(input bit enc, input bit dec, input logic [127:0] pt,
                          input logic [127:0] ct, input logic [127:0] key);
    @(negedge clk);
    start_encryption      = enc;
    start_decryption      = dec;
    plaintext_encryption  = pt;
    cyphertext_decryption = ct;
    key_encryption        = key;
    @(posedge clk);
    #1;
    start_encryption = 1'b0;
    start_decryption = 1'b0;
  endtask

  // Wait for the matching done pulse, then compare against the queued expectation
  task automatic wait_result(input int exp_lat, input bit inject, output logic [127:0] res);
    exp_t e;
    int   n = 0;
    bit   got = 1'b0;
    bit   other = 1'b0;
    string name;
    e = sb_q.pop_front();
    name = e.is_dec ? "dec" : "enc";
    while (!got && n < TIMEOUT) begin
      @(posedge clk);
      n++;
      #1;
      if (inject && n == 3) begin
        start_encryption      = 1'b1;
        start_decryption      = 1'b1;
        plaintext_encryption  = {$urandom(), $urandom(), $urandom(), $urandom()};
        cyphertext_decryption = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_encryption        = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        start_encryption = 1'b0;
        start_decryption = 1'b0;
      end
      if (e.is_dec ? done_decyption : done_encryption) got = 1'b1;
      if (e.is_dec ? done_encryption : done_decyption) other = 1'b1;
    end
    res = e.is_dec ? plaintext_decryption : cyphertext_encryption;
    check({name, "_latency"}, 128'(n), 128'(exp_lat));
    if (e.chk) check({name, "_result"}, res, e.exp);
    check({name, "_other_done"}, 128'(other), 128'(0));
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, 128'(e.is_dec ? done_decyption : done_encryption), 128'(0));
    $display("[TB] %s result=%h latency=%0d", name, res, n);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] rt_ct;
    bit           saw;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_ct", cyphertext_encryption, '0);
    check("reset_pt", plaintext_decryption, '0);
    check("reset_done_enc", 128'(done_encryption), '0);
    check("reset_done_dec", 128'(done_decyption), '0);
    rst = 1'b1;

    push(1'b0, 1'b1, C_CT);
    start_op(1'b1, 1'b0, C_PT, '0, C_KEY);
    wait_result(10, 1'b0, res);

    push(1'b1, 1'b1, C_PT);
    start_op(1'b0, 1'b1, '0, C_CT, C_KEY);
    wait_result(21, 1'b0, res);

    push(1'b0, 1'b1, B_CT);
    start_op(1'b1, 1'b0, B_PT, '0, B_KEY);
    wait_result(10, 1'b0, res);

    push(1'b0, 1'b1, Z_CT);
    start_op(1'b1, 1'b0, '0, '0, '0);
    wait_result(10, 1'b0, res);

    // Round trip: ciphertext unknown in advance, plaintext must come back
    push(1'b0, 1'b0, '0);
    start_op(1'b1, 1'b0, RT_PT, '0, '0);
    wait_result(10, 1'b0, rt_ct);
    push(1'b1, 1'b1, RT_PT);
    start_op(1'b0, 1'b1, '0, rt_ct, '0);
    wait_result(21, 1'b0, res);

    // Simultaneous starts: encryption only, decryption never completes
    push(1'b0, 1'b1, B_CT);
    start_op(1'b1, 1'b1, B_PT, C_CT, B_KEY);
    wait_result(10, 1'b0, res);
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done_decyption) saw = 1'b1;
    end
    check("dual_start_no_dec", 128'(saw), '0);

    // Start pulses and input changes mid-decryption must not disturb it
    push(1'b1, 1'b1, C_PT);
    start_op(1'b0, 1'b1, '0, C_CT, C_KEY);
    wait_result(21, 1'b1, res);

    // Reset during encryption round 5
    start_op(1'b1, 1'b0, B_PT, '0, B_KEY);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ct", cyphertext_encryption, '0);
    check("abort_pt", plaintext_decryption, '0);
    check("abort_done_enc", 128'(done_encryption), '0);
    check("abort_done_dec", 128'(done_decyption), '0);
    rst = 1'b1;
    $display("[TB] reset during encryption round 5");

    push(1'b0, 1'b1, C_CT);
    start_op(1'b1, 1'b0, C_PT, '0, C_KEY);
    wait_result(10, 1'b0, res);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/aes_core.md
Name: aes_core

Overview:
AES-128 (FIPS-197) block-cipher engine that performs one encryption or one decryption at a time, iterating one round per clock.
- Encryption and decryption share a single 128-bit key input (key_encryption).
- Used as a standalone crypto accelerator behind a simple start/done handshake.

Parameters:
DATA_WIDTH, 128, block and key width; taken from aes_package, fixed for AES-128.
NUM_ROUNDS, 10, AES-128 round count; aes_package constant.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-low reset.
start_encryption  input  1  one-cycle pulse; begins encryption of plaintext_encryption.
start_decryption  input  1  one-cycle pulse; begins decryption of cyphertext_decryption.
plaintext_encryption  input  128  encryption input block.
cyphertext_decryption  input  128  decryption input block.
key_encryption  input  128  cipher key, used by both operations.
cyphertext_encryption  output  128  encryption result.
plaintext_decryption  output  128  decryption result.
done_encryption  output  1  one-cycle pulse when cyphertext_encryption is valid.
done_decyption  output  1  one-cycle pulse when plaintext_decryption is valid.

Behaviour:
- Byte order: bit[127:120] is FIPS byte 0. State is column-major (bytes 0-3 form column 0).
- Reset (rst=0 at a clock edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - Internal state and round-key registers are cleared.
  - Reset wins over any start pulse in the same cycle and aborts any operation in progress.
- FSM states: IDLE, ENC, KEXP, DEC.
- IDLE:
  - start_encryption=1: latch the block and key, state <= plaintext ^ key, round counter = 1, go to ENC.
  - Else start_decryption=1: latch the block and key, round counter = 1, go to KEXP.
  - Both starts high together: encryption wins; the decryption start is dropped.
- ENC:
  - Each cycle applies one round: SubBytes, ShiftRows, MixColumns (MixColumns skipped in round 10), then AddRoundKey.
  - The round key is generated on the fly from the previous round key, using RotWord/SubWord/Rcon.
  - After round 10: register the state into cyphertext_encryption, pulse done_encryption for one cycle, return to IDLE.
  - Latency: done_encryption is high in the 10th cycle after the start-sampling edge.
- KEXP:
  - Forward key expansion, one round key per cycle, stored in an 11x128 round-key array.
  - Runs 10 cycles, then sets state <= block ^ rk[10] and goes to DEC.
- DEC:
  - Each cycle applies one inverse round: InvShiftRows, InvSubBytes, AddRoundKey(rk[10-i]), then InvMixColumns (InvMixColumns skipped in the final round).
  - After 10 rounds: register the state into plaintext_decryption, pulse done_decyption, return to IDLE.
  - Total latency is 21 cycles from the start-sampling edge.
- Start pulses received outside IDLE are ignored; no queuing.
- Inputs are sampled only on the start cycle. Input changes during an operation have no effect.
- Result outputs hold their value until overwritten by the next completion of the same operation, or until reset.
- done_* are never high simultaneously with each other. Each is high for exactly one cycle per operation.

Decomposition:
- aes_package holds:
  - DATA_WIDTH and NUM_ROUNDS.
  - SBOX and INV_SBOX as 256x8 constant arrays.
  - RCON[1..10].
  - The state typedef (4x4 bytes).
  - The fsm_state_t enum.
  - Functions xtime, sub_word, rot_word, mix_columns and inv_mix_columns.
- One natural sub-module: aes_key_expand, computing next round key = f(previous key, round index). It is combinational and shared by ENC and KEXP.

Test Plan:
- FIPS-197 App. C.1:
  - Encryption: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> cyphertext_encryption 69c4e0d86a7b0430d8cdb78070b4c55a, done_encryption pulse 10 cycles after start.
  - Decryption: feeding 69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> plaintext_decryption 00112233445566778899aabbccddeeff, done_decyption pulse 21 cycles after start.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Zero-key round trip:
  - Key 0, plaintext 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Key 0, plaintext 00000101030307070f0f1f1f3f3f7f7f: encrypt, then decrypt the result -> plaintext_decryption equals the original block.
- Protocol:
  - start_encryption and start_decryption asserted in the same cycle -> only encryption runs; no done_decyption pulse.
  - Start pulse mid-operation -> ignored; the original result is unaffected.
- Reset: assert rst=0 in ENC round 5 -> next edge all outputs are 0 and FSM is IDLE; a new start after release produces the correct result.
